i2c_slave_engine: RTL and testbench



---
 rtl/i2c_pkg.sv | 11 +
 rtl/i2c_bus_sync.sv | 39 +++
 rtl/i2c_slave_engine.sv | 126 ++++++++++++
 tb/tb_i2c_slave_engine.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states and bus-level bit meanings.
package i2c_pkg;
  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP
  } i2c_slv_state_t;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;
endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer with SCL edge and START/STOP condition detection.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);
  logic [SYNC_STAGES-1:0] scl_ff, sda_ff;
  logic scl_s, scl_d, sda_d;

  // Idle bus is pulled high, so the chain resets to ones to avoid false edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_ff <= '1;
      sda_ff <= '1;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[SYNC_STAGES-2:0], scl};
      sda_ff <= {sda_ff[SYNC_STAGES-2:0], sda};
      scl_d  <= scl_s;
      sda_d  <= sda_s;
    end
  end

  assign scl_s     = scl_ff[SYNC_STAGES-1];
  assign sda_s     = sda_ff[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
endmodule

// File: rtl/i2c_slave_engine.sv
// Bit-level I2C target: address match, byte receive/transmit and ACK drive.
module i2c_slave_engine
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  input  logic [6:0] own_address,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       data_valid,
  output logic       busy
);
  i2c_slv_state_t state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       rw, drive_low;
  logic       sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda),
    .sda_s(sda_s), .scl_rise(scl_rise), .scl_fall(scl_fall),
    .start_det(start_det), .stop_det(stop_det)
  );

  // Gated by rst_n so the bus is released in the very cycle reset asserts.
  assign sda = (drive_low && rst_n) ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      rw         <= I2C_RW_WRITE;
      drive_low  <= 1'b0;
      rdata      <= 8'h00;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (start_det) begin
        state     <= ADDR;
        bit_cnt   <= 3'd0;
        drive_low <= 1'b0;
      end else if (stop_det) begin
        state     <= IDLE;
        bit_cnt   <= 3'd0;
        drive_low <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shreg   <= {shreg[6:0], sda_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (shreg[6:0] == own_address) begin
                state <= ADDR_ACK;
                busy  <= 1'b1;
                rw    <= sda_s;
              end else begin
                state <= WAIT_STOP;
              end
            end
          end
          // First fall drives the ACK, the second releases it and moves on.
          ADDR_ACK: if (scl_fall) begin
            if (!drive_low) begin
              drive_low <= 1'b1;
            end else if (rw == I2C_RW_READ) begin
              state     <= TX;
              shreg     <= wdata;
              drive_low <= ~wdata[7];
              bit_cnt   <= 3'd0;
            end else begin
              state     <= RX;
              drive_low <= 1'b0;
            end
          end
          RX: if (scl_rise) begin
            shreg   <= {shreg[6:0], sda_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rdata      <= {shreg[6:0], sda_s};
              data_valid <= 1'b1;
              state      <= RX_ACK;
            end
          end
          RX_ACK: if (scl_fall) begin
            if (!drive_low) begin
              drive_low <= 1'b1;
            end else begin
              drive_low <= 1'b0;
              state     <= RX;
            end
          end
          TX: if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              drive_low <= 1'b0;
              bit_cnt   <= 3'd0;
              state     <= TX_ACK;
            end else begin
              shreg     <= {shreg[6:0], 1'b0};
              drive_low <= ~shreg[6];
              bit_cnt   <= bit_cnt + 3'd1;
            end
          end
          // The rise always precedes the fall here, so a NACK exits first.
          TX_ACK: begin
            if (scl_rise && sda_s == I2C_NACK) begin
              state <= WAIT_STOP;
            end else if (scl_fall) begin
              state     <= TX;
              shreg     <= wdata;
              drive_low <= ~wdata[7];
              bit_cnt   <= 3'd0;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_slave_engine.sv
// Bench for i2c_slave_engine: bit-banged I2C master plus transaction-level model.
module tb_i2c_slave_engine;
  localparam time Q = 50ns;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl;
  logic       sda_m;
  logic [6:0] own_address;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       data_valid;
  logic       busy;
  wire        sda;

  int n_cmp = 0;
  int n_err = 0;
  int low_cnt = 0;
  logic [7:0] got_q[$];

  assign sda = sda_m ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_engine #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda),
    .own_address(own_address), .wdata(wdata),
    .rdata(rdata), .data_valid(data_valid), .busy(busy)
  );

  always #5ns clk = ~clk;

  always @(negedge clk) begin
    if (data_valid) got_q.push_back(rdata);
    if (!sda_m && sda === 1'b0) low_cnt++;
  end

  task automatic bus_bit(input logic val, output logic smp);
    #Q sda_m = ~val;
    #Q scl = 1'b1;
    #Q smp = (sda === 1'b0) ? 1'b0 : 1'b1;
    #Q scl = 1'b0;
  endtask

  task automatic bus_start();
    #Q sda_m = 1'b0;
    #Q scl = 1'b1;
    #Q sda_m = 1'b1;
    #Q scl = 1'b0;
  endtask

  task automatic bus_stop();
    #Q sda_m = 1'b1;
    #Q scl = 1'b1;
    #Q sda_m = 1'b0;
    #Q;
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, ack);
  endtask

  task automatic rd_byte(input logic mack, input logic [7:0] nxt, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      b[i] = s;
    end
    wdata = nxt;
    bus_bit(mack, s);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scl = 1'b1; sda_m = 1'b0; own_address = 7'h42; wdata = 8'h00;
    #25ns;
    n_cmp++; if (rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata got %h want 00", rdata); end
    n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL reset_dv got %b want 0", data_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (sda !== 1'b1) begin n_err++; $display("FAIL reset_sda got %b want released", sda); end
    rst_n = 1'b1;
    #100ns;
  endtask

  task automatic test_addr_write();
    logic a0, a1;
    own_address = 7'h42; got_q.delete();
    bus_start();
    wr_byte(8'h84, a0);
    n_cmp++; if (a0 !== 1'b0) begin n_err++; $display("FAIL aw_addr_ack got %b want 0", a0); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL aw_busy got %b want 1", busy); end
    wr_byte(8'hA5, a1);
    n_cmp++; if (a1 !== 1'b0) begin n_err++; $display("FAIL aw_data_ack got %b want 0", a1); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL aw_busy_pre_stop got %b want 1", busy); end
    bus_stop();
    #100ns;
    n_cmp++; if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin
      n_err++; $display("FAIL aw_dv count %0d first %h want 1 x A5", got_q.size(), got_q.size() ? got_q[0] : 8'h00); end
    n_cmp++; if (rdata !== 8'hA5) begin n_err++; $display("FAIL aw_rdata got %h want A5", rdata); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL aw_busy_post_stop got %b want 0", busy); end
  endtask

  task automatic test_mismatch();
    logic a0, a1;
    own_address = 7'h42; got_q.delete(); low_cnt = 0;
    bus_start();
    wr_byte(8'h86, a0);
    wr_byte(8'h00, a1);
    bus_stop();
    #100ns;
    n_cmp++; if (a0 !== 1'b1 || a1 !== 1'b1) begin n_err++; $display("FAIL mm_ack got %b%b want 11", a0, a1); end
    n_cmp++; if (low_cnt != 0) begin n_err++; $display("FAIL mm_sda_driven got %0d cycles want 0", low_cnt); end
    n_cmp++; if (got_q.size() != 0) begin n_err++; $display("FAIL mm_dv got %0d want 0", got_q.size()); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mm_busy got %b want 0", busy); end
  endtask

  task automatic test_read();
    logic a0; logic [7:0] b0, b1;
    own_address = 7'h42; wdata = 8'h3C;
    bus_start();
    wr_byte(8'h85, a0);
    rd_byte(1'b0, 8'hC3, b0);
    rd_byte(1'b1, 8'h00, b1);
    #Q;
    n_cmp++; if (sda !== 1'b1) begin n_err++; $display("FAIL rd_release got %b want released", sda); end
    bus_stop();
    n_cmp++; if (a0 !== 1'b0) begin n_err++; $display("FAIL rd_addr_ack got %b want 0", a0); end
    n_cmp++; if (b0 !== 8'h3C) begin n_err++; $display("FAIL rd_byte0 got %h want 3C", b0); end
    n_cmp++; if (b1 !== 8'hC3) begin n_err++; $display("FAIL rd_byte1 got %h want C3", b1); end
  endtask

  task automatic test_rep_start();
    logic a0, a1, a2; logic [7:0] b, wd;
    own_address = 7'h42; got_q.delete();
    wd = 8'($urandom);
    bus_start();
    wr_byte(8'h84, a0);
    wr_byte(8'h11, a1);
    wdata = wd;
    bus_start();
    wr_byte(8'h85, a2);
    rd_byte(1'b1, 8'h00, b);
    bus_stop();
    #100ns;
    n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_err++; $display("FAIL rs_acks got %b want 000", {a0, a1, a2}); end
    n_cmp++; if (rdata !== 8'h11 || got_q.size() != 1) begin
      n_err++; $display("FAIL rs_rdata got %h (%0d pulses) want 11 (1)", rdata, got_q.size()); end
    n_cmp++; if (b !== wd) begin n_err++; $display("FAIL rs_tx got %h want %h", b, wd); end
  endtask

  task automatic test_reset_mid_ack();
    logic s;
    own_address = 7'h42;
    bus_start();
    for (int i = 7; i >= 0; i--) bus_bit(((8'h84 >> i) & 8'h1) != 0, s);
    #Q sda_m = 1'b0;
    n_cmp++; if (sda !== 1'b0) begin n_err++; $display("FAIL rst_ack_driven got %b want 0", sda); end
    rst_n = 1'b0;
    #1ns;
    n_cmp++; if (sda !== 1'b1) begin n_err++; $display("FAIL rst_sda got %b want released", sda); end
    n_cmp++; if (rdata !== 8'h00 || data_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rst_outputs got rdata=%h dv=%b busy=%b want 00/0/0", rdata, data_valid, busy); end
    #20ns rst_n = 1'b1;
    scl = 1'b0;
    bus_stop();
    #100ns;
  endtask

  task automatic test_stop_in_rx();
    logic a0, a1, s; logic [7:0] b;
    own_address = 7'h42; got_q.delete();
    b = 8'($urandom);
    bus_start();
    wr_byte(8'h84, a0);
    for (int i = 0; i < 4; i++) bus_bit(1'($urandom), s);
    bus_stop();
    #100ns;
    n_cmp++; if (got_q.size() != 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL sr_abort got %0d pulses busy=%b want 0/0", got_q.size(), busy); end
    bus_start();
    wr_byte(8'h84, a0);
    wr_byte(b, a1);
    bus_stop();
    #100ns;
    n_cmp++; if (got_q.size() != 1 || got_q[0] !== b || a1 !== 1'b0) begin
      n_err++; $display("FAIL sr_next got %0d pulses ack=%b want 1 x %h ack 0", got_q.size(), a1, b); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 10; t++) begin
      logic [6:0] own, addr; logic match, rnw, a; int n;
      logic [7:0] exp_q[$], obs_q[$], wd[$], b;
      logic [7:0] ack_got, ack_exp;
      own = 7'($urandom); match = ($urandom_range(0, 2) != 0); rnw = 1'($urandom);
      addr = match ? own : (own ^ 7'($urandom_range(1, 127)));
      n = $urandom_range(1, 3);
      own_address = own; got_q.delete(); ack_got = '0; ack_exp = '0;
      for (int i = 0; i < n + 1; i++) wd.push_back(8'($urandom));
      wdata = wd[0];
      bus_start();
      wr_byte({addr, rnw}, a);
      ack_got[0] = a; ack_exp[0] = !match;
      for (int i = 0; i < n; i++) begin
        if (rnw) begin
          rd_byte(i == n - 1, wd[i + 1], b);
          obs_q.push_back(b);
          exp_q.push_back(match ? wd[i] : 8'hFF);
          if (!match) break;
        end else begin
          b = 8'($urandom);
          wr_byte(b, a);
          ack_got[i + 1] = a; ack_exp[i + 1] = !match;
          if (match) exp_q.push_back(b);
        end
      end
      bus_stop();
      #100ns;
      if (!rnw) obs_q = got_q;
      else begin
        n_cmp++; if (got_q.size() != 0) begin n_err++; $display("FAIL rnd%0d_read_dv got %0d want 0", t, got_q.size()); end
      end
      n_cmp++; if (ack_got !== ack_exp) begin n_err++; $display("FAIL rnd%0d_acks got %b want %b", t, ack_got, ack_exp); end
      n_cmp++; if (obs_q != exp_q) begin
        n_err++; $display("FAIL rnd%0d_data rnw=%b got %0d bytes want %0d", t, rnw, obs_q.size(), exp_q.size()); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rnd%0d_busy got %b want 0", t, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_addr_write();
    test_mismatch();
    test_read();
    test_rep_start();
    test_reset_mid_ack();
    test_stop_in_rx();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
